// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution patch scheduler.
//   state_t        - FSM state encoding (ST_IDLE, ST_SCAN, ST_DONE)
//   *_DEF          - default image geometry and counter/coordinate widths
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int CW_DEF    = 5;
  localparam int NW_DEF    = 10;

endpackage

// File: rtl/axis_stepper.sv
// axis_stepper: one window coordinate along a single image axis.
//   clk      rising-edge clock
//   rst      synchronous active-low reset (coordinate -> 0)
//   clr_i    force the coordinate to 0 (frame start / abort)
//   adv_i    advance by step_i, wrapping to 0 past limit_i
//   step_i   latched stride
//   limit_i  largest legal coordinate (IMG - patch), CW+1 bits
//   coord_o  current coordinate
//   wrap_o   the next advance would pass limit_i (coordinate is at its last position)
module axis_stepper
  import conv_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [2:0]    step_i,
  input  logic [CW:0]   limit_i,
  output logic [CW-1:0] coord_o,
  output logic          wrap_o
);

  logic [CW-1:0] coord_q, coord_d;
  logic [CW:0]   sum;

  // One extra bit so coord + step can never wrap before the limit compare.
  assign sum    = {1'b0, coord_q} + {{(CW-2){1'b0}}, step_i};
  assign wrap_o = (sum > limit_i);

  always_comb begin
    coord_d = coord_q;
    if (clr_i) begin
      coord_d = '0;
    end else if (adv_i) begin
      coord_d = wrap_o ? '0 : sum[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      coord_q <= '0;
    end else begin
      coord_q <= coord_d;
    end
  end

  assign coord_o = coord_q;

endmodule

// File: rtl/conv_patch_scheduler.sv
// conv_patch_scheduler: walks a patch_size x patch_size window over an
// IMG_W x IMG_H image in raster order with a programmable stride and hands
// each top-left coordinate downstream over a valid/ready handshake.
//   clk, rst            clock, synchronous active-low reset
//   start, abort        frame start (IDLE only) / drop current frame
//   stride, patch_size  frame configuration, latched on a start in IDLE
//   patch_ready         downstream accepts a coordinate
//   patch_valid/_x/_y   current window position
//   last_patch          final window of the frame (with patch_valid)
//   patch_idx           raster index of the current window
//   busy, done, cfg_err scanning / end-of-frame pulse / rejected-start pulse
module conv_patch_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = CW_DEF,
  parameter int NW    = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    stride,
  input  logic [2:0]    patch_size,
  input  logic          patch_ready,
  output logic          patch_valid,
  output logic [CW-1:0] patch_x,
  output logic [CW-1:0] patch_y,
  output logic          last_patch,
  output logic [NW-1:0] patch_idx,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam logic [CW:0] IMG_W_L = (CW+1)'(IMG_W);
  localparam logic [CW:0] IMG_H_L = (CW+1)'(IMG_H);

  state_t        state_q;
  logic [2:0]    s_q, p_q;
  logic          valid_q, busy_q, done_q, cfg_err_q;
  logic [NW-1:0] idx_q;

  logic [CW:0]   p_ext, psz_ext, xmax, ymax;
  logic          cfg_ok, accept, xfer, clr, adv_x, adv_y;
  logic          x_wrap, y_wrap, last;

  assign p_ext   = {{(CW-2){1'b0}}, p_q};
  assign psz_ext = {{(CW-2){1'b0}}, patch_size};
  // Only meaningful while scanning, where p_q has already been validated.
  assign xmax    = IMG_W_L - p_ext;
  assign ymax    = IMG_H_L - p_ext;

  assign cfg_ok  = (stride != 3'd0) && (patch_size != 3'd0) &&
                   (psz_ext <= IMG_W_L) && (psz_ext <= IMG_H_L);

  // Abort beats a simultaneous start in IDLE.
  assign accept  = (state_q == ST_IDLE) && start && !abort;
  assign xfer    = valid_q && patch_ready;
  assign clr     = accept || (abort && (state_q != ST_IDLE));
  assign adv_x   = xfer && !abort;
  assign adv_y   = adv_x && x_wrap;
  assign last    = x_wrap && y_wrap;

  axis_stepper #(.CW(CW)) u_x (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .adv_i  (adv_x),
    .step_i (s_q),
    .limit_i(xmax),
    .coord_o(patch_x),
    .wrap_o (x_wrap)
  );

  axis_stepper #(.CW(CW)) u_y (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .adv_i  (adv_y),
    .step_i (s_q),
    .limit_i(ymax),
    .coord_o(patch_y),
    .wrap_o (y_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      p_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            s_q <= stride;
            p_q <= patch_size;
            if (cfg_ok) begin
              state_q <= ST_SCAN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              idx_q   <= '0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (xfer) begin
            idx_q <= idx_q + NW'(1);
            if (last) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign patch_valid = valid_q;
  assign last_patch  = valid_q && last;
  assign patch_idx   = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_conv_patch_scheduler.sv
// Directed bench: a 28x28 scheduler (A), a 4x4 scheduler (B) and a 6x6
// scheduler (C) share clock, reset, abort, stride, patch_size and ready;
// each has its own start.
module tb_conv_patch_scheduler;

  logic       clk;
  logic       rst;
  logic       start_a, start_b, start_c;
  logic       abort;
  logic [2:0] stride, patch_size;
  logic       patch_ready;

  logic       valid_a, last_a, busy_a, done_a, err_a;
  logic [4:0] x_a, y_a;
  logic [9:0] idx_a;
  logic       valid_b, last_b, busy_b, done_b, err_b;
  logic [4:0] x_b, y_b;
  logic [9:0] idx_b;
  logic       valid_c, last_c, busy_c, done_c, err_c;
  logic [4:0] x_c, y_c;
  logic [9:0] idx_c;

  int total = 0;
  int bad   = 0;

  conv_patch_scheduler #(.IMG_W(28), .IMG_H(28), .CW(5), .NW(10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort),
    .stride(stride), .patch_size(patch_size), .patch_ready(patch_ready),
    .patch_valid(valid_a), .patch_x(x_a), .patch_y(y_a), .last_patch(last_a),
    .patch_idx(idx_a), .busy(busy_a), .done(done_a), .cfg_err(err_a)
  );

  conv_patch_scheduler #(.IMG_W(4), .IMG_H(4), .CW(5), .NW(10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort),
    .stride(stride), .patch_size(patch_size), .patch_ready(patch_ready),
    .patch_valid(valid_b), .patch_x(x_b), .patch_y(y_b), .last_patch(last_b),
    .patch_idx(idx_b), .busy(busy_b), .done(done_b), .cfg_err(err_b)
  );

  conv_patch_scheduler #(.IMG_W(6), .IMG_H(6), .CW(5), .NW(10)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort),
    .stride(stride), .patch_size(patch_size), .patch_ready(patch_ready),
    .patch_valid(valid_c), .patch_x(x_c), .patch_y(y_c), .last_patch(last_c),
    .patch_idx(idx_c), .busy(busy_c), .done(done_c), .cfg_err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int ex, ey, n, cyc;
    logic r;

    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    abort = 1'b0; stride = 3'd0; patch_size = 3'd0; patch_ready = 1'b1;
    step();
    step();
    chk("rst_valid", valid_a, 0);
    chk("rst_x",     x_a, 0);
    chk("rst_y",     y_a, 0);
    chk("rst_last",  last_a, 0);
    chk("rst_idx",   idx_a, 0);
    chk("rst_busy",  busy_a, 0);
    chk("rst_done",  done_a, 0);
    chk("rst_err",   err_a, 0);
    rst = 1'b1;
    step();

    // Frame 1: P=4, S=3, ready always high -> 9x9 windows.
    stride = 3'd3; patch_size = 3'd4; patch_ready = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 81; k++) begin
      chk("t1_valid", valid_a, 1);
      chk("t1_busy",  busy_a, 1);
      chk("t1_x",     x_a, (k % 9) * 3);
      chk("t1_y",     y_a, (k / 9) * 3);
      chk("t1_idx",   idx_a, k);
      chk("t1_last",  last_a, (k == 80) ? 1 : 0);
      chk("t1_done",  done_a, 0);
      step();
    end
    chk("t1_done_pulse", done_a, 1);
    chk("t1_done_valid", valid_a, 0);
    chk("t1_done_busy",  busy_a, 0);
    step();
    chk("t1_done_once",  done_a, 0);
    chk("t1_idle_busy",  busy_a, 0);

    // Frame 2: P=5, S=2, random ready -> 12x12 windows, x in 0..22.
    stride = 3'd2; patch_size = 3'd5; patch_ready = 1'b0; start_a = 1'b1;
    step();
    start_a = 1'b0;
    ex = 0; ey = 0; n = 0; cyc = 0;
    while (n < 144 && cyc < 3000) begin
      chk("t2_valid", valid_a, 1);
      chk("t2_x",     x_a, ex);
      chk("t2_y",     y_a, ey);
      chk("t2_idx",   idx_a, n);
      chk("t2_last",  last_a, (ex == 22 && ey == 22) ? 1 : 0);
      chk("t2_done",  done_a, 0);
      r = 1'($urandom_range(0, 1));
      patch_ready = r;
      step();
      cyc++;
      if (r) begin
        n++;
        if (ex + 2 <= 23) ex += 2;
        else begin ex = 0; ey += 2; end
      end
    end
    chk("t2_count", n, 144);
    chk("t2_done_pulse", done_a, 1);
    patch_ready = 1'b1;
    step();

    // Rejected configurations.
    stride = 3'd0; patch_size = 3'd3; start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("t3a_err",   err_a, 1);
    chk("t3a_busy",  busy_a, 0);
    chk("t3a_valid", valid_a, 0);
    step();
    chk("t3a_err_pulse", err_a, 0);
    chk("t3a_valid2",    valid_a, 0);

    stride = 3'd1; patch_size = 3'd0; start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("t3b_err",   err_a, 1);
    chk("t3b_busy",  busy_a, 0);
    chk("t3b_valid", valid_a, 0);
    step();
    chk("t3b_err_pulse", err_a, 0);

    stride = 3'd1; patch_size = 3'd7; start_c = 1'b1;
    step();
    start_c = 1'b0;
    chk("t3c_err",   err_c, 1);
    chk("t3c_busy",  busy_c, 0);
    chk("t3c_valid", valid_c, 0);
    step();
    chk("t3c_err_pulse", err_c, 0);
    chk("t3c_valid2",    valid_c, 0);

    // Single window on a 4x4 image.
    stride = 3'd1; patch_size = 3'd4; patch_ready = 1'b1; start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("t4_valid", valid_b, 1);
    chk("t4_last",  last_b, 1);
    chk("t4_x",     x_b, 0);
    chk("t4_y",     y_b, 0);
    chk("t4_idx",   idx_b, 0);
    chk("t4_err",   err_b, 0);
    step();
    chk("t4_done",   done_b, 1);
    chk("t4_valid2", valid_b, 0);
    step();
    chk("t4_done_once", done_b, 0);

    // Abort during the 10th window, with a start at the same time.
    stride = 3'd3; patch_size = 3'd4; patch_ready = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 9; k++) step();
    chk("t5_idx", idx_a, 9);
    chk("t5_x",   x_a, 0);
    chk("t5_y",   y_a, 3);
    abort = 1'b1; start_a = 1'b1;
    step();
    abort = 1'b0; start_a = 1'b0;
    chk("t5_abort_valid", valid_a, 0);
    chk("t5_abort_busy",  busy_a, 0);
    chk("t5_abort_done",  done_a, 0);
    step();
    chk("t5_no_done",  done_a, 0);
    chk("t5_no_start", valid_a, 0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("t5_restart_valid", valid_a, 1);
    chk("t5_restart_x",     x_a, 0);
    chk("t5_restart_y",     y_a, 0);
    chk("t5_restart_idx",   idx_a, 0);

    // Reset mid-frame.
    step();
    step();
    chk("t6_pre_idx", idx_a, 2);
    chk("t6_pre_x",   x_a, 6);
    rst = 1'b0;
    step();
    chk("t6_valid", valid_a, 0);
    chk("t6_x",     x_a, 0);
    chk("t6_y",     y_a, 0);
    chk("t6_last",  last_a, 0);
    chk("t6_idx",   idx_a, 0);
    chk("t6_busy",  busy_a, 0);
    chk("t6_done",  done_a, 0);
    chk("t6_err",   err_a, 0);
    rst = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("t6_restart_valid", valid_a, 1);
    chk("t6_restart_x",     x_a, 0);
    chk("t6_restart_y",     y_a, 0);
    chk("t6_restart_idx",   idx_a, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_patch_scheduler.md
Name: conv_patch_scheduler

Overview:
- Sequences the convolution datapath across one image frame.
- Walks a patch_size x patch_size window over an IMG_W x IMG_H boolean image in raster order with a programmable stride.
- For each window position it issues the top-left coordinate to the patch extractor / clause-evaluation stage over a valid/ready handshake.
- Frames start on command; completion is flagged with a done pulse.

Parameters:
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
- CW, 5, coordinate width; must satisfy 2^CW > max(IMG_W, IMG_H).
- NW, 10, patch counter width; must hold IMG_W*IMG_H.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-low reset: sampled on clk, 0 = reset.
- start  input  1  one-cycle frame start; ignored unless state is IDLE.
- abort  input  1  drop the current frame and return to IDLE.
- stride  input  3  window step; latched on an accepted start.
- patch_size  input  3  window edge; latched on an accepted start.
- patch_ready  input  1  downstream can accept a coordinate.
- patch_valid  output  1  patch_x/patch_y hold a valid window position.
- patch_x  output  CW  window top-left column.
- patch_y  output  CW  window top-left row.
- last_patch  output  1  qualifies the final window of the frame (valid only with patch_valid).
- patch_idx  output  NW  raster index of the current window, 0-based.
- busy  output  1  high in SCAN.
- done  output  1  one-cycle pulse after the last handshake.
- cfg_err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- States:
  - IDLE: waits for start.
  - SCAN: issues window positions.
  - DONE: one cycle, then returns to IDLE.
- Reset (rst=0 at a clk edge): state=IDLE. All outputs are 0: patch_valid, patch_x, patch_y, last_patch, patch_idx, busy, done, cfg_err. Latched stride and patch_size are cleared to 0.
- Accepting a start in IDLE:
  - Latch stride and patch_size into s_q and p_q.
  - Validate the configuration:
    - stride==0 → reject.
    - patch_size==0 → reject.
    - patch_size > IMG_W or patch_size > IMG_H → reject.
  - On reject: cfg_err=1 for the next cycle only; remain in IDLE.
  - On accept: next cycle is SCAN with x=0, y=0, patch_idx=0, patch_valid=1. Start-to-first-valid latency is 1 cycle.
- Scan limits: XMAX = IMG_W - p_q and YMAX = IMG_H - p_q, computed in CW+1 bits.
- Handshake:
  - A transfer occurs when patch_valid && patch_ready.
  - While patch_ready=0, every output holds stable.
  - patch_valid never drops in SCAN without a transfer, except on abort.
- Advance on each transfer:
  - If x + s_q <= XMAX: x += s_q.
  - Else x=0 and y += s_q.
  - patch_idx increments on every transfer.
  - All comparisons use CW+1 bits, so x + s_q never wraps.
- last_patch = (x + s_q > XMAX) && (y + s_q > YMAX).
  - A transfer with last_patch=1 moves to DONE.
  - In DONE: done=1 and patch_valid=0.
  - The following cycle: IDLE, busy=0.
- Windows per axis = floor((IMG - P)/S) + 1. The total per frame is the product of both axes.
- Boundary cases:
  - P == IMG dimension: only one position on that axis.
  - P == IMG_W and P == IMG_H: a single window with last_patch=1 on the first cycle.
  - start while in SCAN or DONE: ignored.
  - abort in SCAN or DONE: next state IDLE with patch_valid=0 and no done pulse; abort also wins over a simultaneous transfer.
  - abort in IDLE: no effect; if start and abort arrive together in IDLE, abort wins and start is ignored.
  - rst=0 mid-frame: returns to the reset values on the next edge.
- Changes on the stride and patch_size inputs after the latch have no effect until the next start.

Decomposition:
- Shared package conv_pkg holds:
  - the state encoding constants ST_IDLE, ST_SCAN, ST_DONE;
  - defaults for the image geometry and CW/NW.
- Sub-module axis_stepper: one coordinate register, step-by-s_q logic, wrap-to-0 and the at-limit flag.
  - Instanced twice: the x stepper advances on a transfer; the y stepper advances when x wraps.
- Top level holds the FSM, the patch_idx counter and config validation.

Test Plan:
1. Frame at IMG 28x28, patch_size=4, stride=3, patch_ready tied 1 → 81 valid cycles. Order is x = 0,3,…,24 on each row, y stepping by 3. last_patch only at (24,24) with patch_idx=80; done pulses exactly once, the cycle after.
2. Same frame with patch_size=5, stride=2 and patch_ready toggling pseudo-randomly → 144 transfers with x ∈ {0,…,22}. Outputs stay stable on every ready=0 cycle; the final window is (22,22).
3. Config rejects:
   - stride=0 → cfg_err pulse, busy stays 0, no patch_valid;
   - patch_size=0 → same response;
   - patch_size=7 with IMG_W=IMG_H=6 → same response.
4. Single window: IMG 4x4 with patch_size=4, stride=1 → one cycle with patch_valid=1 and last_patch=1 at (0,0), then done.
5. abort during the 10th window, with a simultaneous start → IDLE next cycle, no done pulse. A fresh start then begins at (0,0) with patch_idx=0.
6. rst=0 for one cycle mid-frame → all outputs read 0 on the next edge; a start re-issued in IDLE returns the first valid at (0,0) with 1-cycle latency.
